vga_fill_engine: RTL and testbench
==================================

# vga_fill_engine

Rectangle-fill sequencer for the VGA peripheral at 0xB0–0xB2. Sits between the microprocessor bus and the VGA bus port. The CPU loads corner coordinates and a start command over the bus. The engine then issues the per-pixel Y/X address writes that set frame-buffer bits, interleaving with CPU traffic. CPU writes always take priority; the engine only uses idle bus cycles.

## Interface
- `XMax`, default 8'd159: last valid X column, clamp limit.
- `YMax`, default 7'd119: last valid Y row, clamp limit.
- `BaseAddr`, default 8'hB4: X0 register address; Y0 = +1, X1 = +2, Y1 = +3, CTRL = +4.
- `VGAXAddr`, default 8'hB1: VGA X-address register target.
- `VGAYAddr`, default 8'hB2: VGA Y-address register target.
- `CLK` in 1: system clock. The only clock.
- `RESET` in 1: synchronous, active-high.
- `BUS_ADDR` in 8: CPU bus address.
- `BUS_DATA` in 8: CPU bus write data.
- `BUS_WE` in 1: CPU bus write strobe.
- `VGA_BUS_ADDR` out 8: address presented to the VGA peripheral.
- `VGA_BUS_DATA` out 8: data presented to the VGA peripheral.
- `VGA_BUS_WE` out 1: write strobe to the VGA peripheral.
- `BUSY` out 1: high while a fill is in progress.
- `DONE_IRQ` out 1: one-cycle pulse on normal fill completion.

## Operation
- Config registers (cleared by reset), written when `BUS_WE` is high and `BUS_ADDR` matches:
  - X0 (8b), Y0 (7b, from `BUS_DATA[6:0]`), X1 (8b), Y1 (7b).
  - CTRL has no storage: `BUS_DATA[0]` = start, `BUS_DATA[1]` = abort.
- Output mux is combinational:
  - If `BUS_WE`=1, the CPU bus passes through unchanged. This includes writes to the engine's own addresses.
  - Otherwise, the engine drives the VGA bus in WR_Y/WR_X states.
  - Otherwise, all VGA bus outputs are 0.
- States: IDLE, LOAD, WR_Y, WR_X, GAP, DONE.
- IDLE: start=1 and abort=0 → LOAD.
- LOAD:
  - Latch working copies: lx0 = X0, ly0 = Y0.
  - lx1 = min(X1, XMax) and ly1 = min(Y1, YMax).
  - Set cursor cx = lx0, cy = ly0.
  - If lx0 > lx1 or ly0 > ly1 (empty rectangle) → DONE. Otherwise → WR_Y.
- WR_Y: drive addr = VGAYAddr, data = {1'b0, cy}, WE = 1 → WR_X.
- WR_X: drive addr = VGAXAddr, data = cx, WE = 1 → GAP.
- GAP:
  - WE = 0 (lets the peripheral commit the pixel).
  - If cx == lx1 and cy == ly1 → DONE.
  - Else if cx == lx1: cx ← lx0, cy ← cy+1, → WR_Y.
  - Else: cx ← cx+1, → WR_Y.
- DONE: `DONE_IRQ` = 1 for this cycle → IDLE.
- Stall: in WR_Y or WR_X, if `BUS_WE`=1 the state and cursor hold and the engine write is retried on the next cycle. Other states are unaffected by CPU traffic.
- Abort: a CTRL write with bit1=1 in any non-IDLE state → IDLE next cycle. No `DONE_IRQ`. Cursor is left as is.
- Start while busy (bit0=1, bit1=0) is ignored.
- Start and abort together in IDLE: no start.
- Coordinate writes while busy update the config registers only. The running fill uses the latched copies.
- Raster order: X inner, Y outer. Counter arithmetic is width-exact; clamping guarantees no wrap.

## Timing
- Reset value of all outputs and registers is 0; state is IDLE.
- `BUSY` = 1 in all states except IDLE, so it is high during DONE.
- The CTRL write is sampled at edge k, giving LOAD in cycle k+1.
- First WR_Y is in cycle k+2.
- Each pixel costs 3 cycles plus stall cycles.
- Uncontended N-pixel fill: `DONE_IRQ` is asserted in cycle k+2+3N.
- Empty rectangle: `DONE_IRQ` is asserted in cycle k+2.
- Reset mid-fill → IDLE next edge with outputs 0. No IRQ.

## Test plan
- Reset, then idle: all outputs are 0 and `BUSY`=0 for 10 cycles, with CPU writes to 0xB0 passing through unchanged on the same cycle.
- Program (10,20)–(11,21) and start:
  - Engine write sequence is (B2,20),(B1,10),(B2,20),(B1,11),(B2,21),(B1,10),(B2,21),(B1,11), each pair followed by one WE=0 gap.
  - `DONE_IRQ` is a single pulse 14 cycles after the CTRL write.
- Same fill with a CPU write on every WR_X cycle: the CPU wins each time, the engine retries with the identical pair, no pixel is skipped, and completion is delayed by exactly the stall count.
- X0=5, X1=3 (empty rectangle): no engine VGA writes, and `DONE_IRQ` 2 cycles after the CTRL write.
- X1=200, Y1=127 from (158,118): only columns 158–159 and rows 118–119 are written (4 pixels).
- Abort after the 3rd pixel (CTRL=0x02): IDLE next cycle, `BUSY`=0, no `DONE_IRQ`, no further engine writes. A following start with CTRL=0x03 is ignored.

Source files
------------

// File: rtl/vga_fill_engine.sv
`timescale 1ns/1ps
// vga_fill_engine: rectangle-fill sequencer that sits between the CPU bus and
// the VGA bus port. It issues Y/X address write pairs for every pixel of a
// clamped rectangle, using only the cycles in which the CPU is not writing.
module vga_fill_engine #(
  parameter logic [7:0] XMax     = 8'd159,
  parameter logic [6:0] YMax     = 7'd119,
  parameter logic [7:0] BaseAddr = 8'hB4,
  parameter logic [7:0] VGAXAddr = 8'hB1,
  parameter logic [7:0] VGAYAddr = 8'hB2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic [7:0] VGA_BUS_ADDR,
  output logic [7:0] VGA_BUS_DATA,
  output logic       VGA_BUS_WE,
  output logic       BUSY,
  output logic       DONE_IRQ
);

  localparam logic [7:0] ADDR_X0   = BaseAddr;
  localparam logic [7:0] ADDR_Y0   = BaseAddr + 8'd1;
  localparam logic [7:0] ADDR_X1   = BaseAddr + 8'd2;
  localparam logic [7:0] ADDR_Y1   = BaseAddr + 8'd3;
  localparam logic [7:0] ADDR_CTRL = BaseAddr + 8'd4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WR_Y = 3'd2;
  localparam logic [2:0] S_WR_X = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0] state_q, state_d;
  logic [7:0] x0_q, x0_d, x1_q, x1_d;
  logic [6:0] y0_q, y0_d, y1_q, y1_d;
  logic [7:0] lx0_q, lx0_d, lx1_q, lx1_d, cx_q, cx_d;
  logic [6:0] ly0_q, ly0_d, ly1_q, ly1_d, cy_q, cy_d;

  logic       ctrl_wr;
  logic       start_cmd;
  logic       abort_cmd;
  logic [7:0] x1_clamp;
  logic [6:0] y1_clamp;

  // CTRL decode (no storage) and clamping of the far corner to the screen.
  always_comb begin
    ctrl_wr   = BUS_WE && (BUS_ADDR == ADDR_CTRL);
    start_cmd = ctrl_wr && BUS_DATA[0] && !BUS_DATA[1];
    abort_cmd = ctrl_wr && BUS_DATA[1];
    x1_clamp  = (x1_q > XMax) ? XMax : x1_q;
    y1_clamp  = (y1_q > YMax) ? YMax : y1_q;
  end

  // Config registers: updated on any matching CPU write, even mid-fill.
  always_comb begin
    x0_d = x0_q;
    y0_d = y0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    if (BUS_WE) begin
      if (BUS_ADDR == ADDR_X0) x0_d = BUS_DATA;
      if (BUS_ADDR == ADDR_Y0) y0_d = BUS_DATA[6:0];
      if (BUS_ADDR == ADDR_X1) x1_d = BUS_DATA;
      if (BUS_ADDR == ADDR_Y1) y1_d = BUS_DATA[6:0];
    end
  end

  // Fill sequencer: latch corners, walk X inside Y, stall on CPU writes.
  always_comb begin
    state_d = state_q;
    lx0_d   = lx0_q;
    ly0_d   = ly0_q;
    lx1_d   = lx1_q;
    ly1_d   = ly1_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    case (state_q)
      S_IDLE: if (start_cmd) state_d = S_LOAD;
      S_LOAD: begin
        lx0_d = x0_q;
        ly0_d = y0_q;
        lx1_d = x1_clamp;
        ly1_d = y1_clamp;
        cx_d  = x0_q;
        cy_d  = y0_q;
        if ((x0_q > x1_clamp) || (y0_q > y1_clamp)) state_d = S_DONE;
        else                                          state_d = S_WR_Y;
      end
      S_WR_Y: if (!BUS_WE) state_d = S_WR_X;
      S_WR_X: if (!BUS_WE) state_d = S_GAP;
      S_GAP: begin
        if ((cx_q == lx1_q) && (cy_q == ly1_q)) begin
          state_d = S_DONE;
        end else if (cx_q == lx1_q) begin
          cx_d    = lx0_q;
          cy_d    = cy_q + 7'd1;
          state_d = S_WR_Y;
        end else begin
          cx_d    = cx_q + 8'd1;
          state_d = S_WR_Y;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides whatever the sequencer wanted; cursor is left alone.
    if (abort_cmd && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // State and register update with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      lx0_q   <= '0;
      ly0_q   <= '0;
      lx1_q   <= '0;
      ly1_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      lx0_q   <= lx0_d;
      ly0_q   <= ly0_d;
      lx1_q   <= lx1_d;
      ly1_q   <= ly1_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  // VGA bus mux: CPU writes always win, engine only drives idle cycles.
  always_comb begin
    VGA_BUS_ADDR = 8'd0;
    VGA_BUS_DATA = 8'd0;
    VGA_BUS_WE   = 1'b0;
    if (BUS_WE) begin
      VGA_BUS_ADDR = BUS_ADDR;
      VGA_BUS_DATA = BUS_DATA;
      VGA_BUS_WE   = 1'b1;
    end else if (state_q == S_WR_Y) begin
      VGA_BUS_ADDR = VGAYAddr;
      VGA_BUS_DATA = {1'b0, cy_q};
      VGA_BUS_WE   = 1'b1;
    end else if (state_q == S_WR_X) begin
      VGA_BUS_ADDR = VGAXAddr;
      VGA_BUS_DATA = cx_q;
      VGA_BUS_WE   = 1'b1;
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    BUSY     = (state_q != S_IDLE);
    DONE_IRQ = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_vga_fill_engine.sv
`timescale 1ns/1ps
// Testbench for vga_fill_engine: a per-cycle monitor pops expected engine
// writes from a scoreboard queue filled by a reference raster model.
module tb_vga_fill_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_addr;
  logic [7:0] bus_data;
  logic       bus_we;
  logic [7:0] vga_addr;
  logic [7:0] vga_data;
  logic       vga_we;
  logic       busy;
  logic       done_irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int irq_count = 0;
  int irq_cycle = -1;
  int irq_busy_bad = 0;
  int busy_hi = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  vga_fill_engine dut (
    .CLK          (clk),
    .RESET        (rst),
    .BUS_ADDR     (bus_addr),
    .BUS_DATA     (bus_data),
    .BUS_WE       (bus_we),
    .VGA_BUS_ADDR (vga_addr),
    .VGA_BUS_DATA (vga_data),
    .VGA_BUS_WE   (vga_we),
    .BUSY         (busy),
    .DONE_IRQ     (done_irq)
  );

  // One clock cycle: drive inputs, sample mid-cycle, scoreboard the VGA bus.
  task automatic step(input logic we, input logic [7:0] addr, input logic [7:0] data);
    logic [15:0] e;
    bus_we = we; bus_addr = addr; bus_data = data;
    #4;
    if (we) begin
      n_tests++;
      if ({vga_we, vga_addr, vga_data} !== {1'b1, addr, data}) begin
        n_fail++;
        $display("[TB] FAIL passthru cyc=%0d got we=%b %h/%h want 1 %h/%h", cyc, vga_we, vga_addr, vga_data, addr, data);
      end
    end else if (vga_we === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_write cyc=%0d got %h/%h want no engine write", cyc, vga_addr, vga_data);
      end else begin
        e = exp_q.pop_front();
        if ({vga_addr, vga_data} !== e) begin
          n_fail++;
          $display("[TB] FAIL engine_write cyc=%0d got %h/%h want %h/%h", cyc, vga_addr, vga_data, e[15:8], e[7:0]);
        end else begin
          $display("[TB] cyc=%0d engine write %h/%h", cyc, vga_addr, vga_data);
        end
      end
    end else begin
      n_tests++;
      if ({vga_we, vga_addr, vga_data} !== 17'd0) begin
        n_fail++;
        $display("[TB] FAIL quiet_bus cyc=%0d got we=%b %h/%h want 0 00/00", cyc, vga_we, vga_addr, vga_data);
      end
    end
    if (done_irq === 1'b1) begin
      irq_count++;
      irq_cycle = cyc;
      if (busy !== 1'b1) irq_busy_bad++;
    end
    if (busy === 1'b1) busy_hi++;
    @(posedge clk); #1;
    cyc++;
  endtask

  // Reference raster model: clamp, then X inner / Y outer, up to max_pix pixels.
  function automatic int push_fill(input int x0, input int y0, input int x1, input int y1, input int max_pix);
    int n = 0;
    logic [7:0] xv, yv;
    if (x1 > 159) x1 = 159;
    if (y1 > 119) y1 = 119;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        if (n < max_pix) begin
          xv = 8'(x); yv = 8'(y);
          exp_q.push_back({8'hB2, yv});
          exp_q.push_back({8'hB1, xv});
          n++;
        end
      end
    end
    return n;
  endfunction

  task automatic program_rect(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1, input logic [7:0] y1);
    step(1'b1, 8'hB4, x0);
    step(1'b1, 8'hB5, y0);
    step(1'b1, 8'hB6, x1);
    step(1'b1, 8'hB7, y1);
  endtask

  // Program, start, wait for the IRQ and check its timing and the scoreboard.
  task automatic run_fill(input string name, input int x0, input int y0, input int x1, input int y1);
    int n, c;
    program_rect(8'(x0), 8'(y0), 8'(x1), 8'(y1));
    n = push_fill(x0, y0, x1, y1, 1000);
    irq_count = 0; irq_cycle = -1; irq_busy_bad = 0;
    c = cyc;
    step(1'b1, 8'hB8, 8'h01);
    for (int i = 0; i < 80 && irq_count == 0; i++) step(1'b0, 8'h00, 8'h00);
    repeat (3) step(1'b0, 8'h00, 8'h00);
    n_tests++;
    if (irq_count != 1) begin
      n_fail++; $display("[TB] FAIL %s irq_count got %0d want 1", name, irq_count);
    end
    n_tests++;
    if (irq_cycle != c + 2 + 3 * n) begin
      n_fail++; $display("[TB] FAIL %s irq_cycle got %0d want %0d", name, irq_cycle - c, 2 + 3 * n);
    end
    n_tests++;
    if (exp_q.size() != 0 || irq_busy_bad != 0) begin
      n_fail++; $display("[TB] FAIL %s leftover got %0d writes busy_bad=%0d want 0 0", name, exp_q.size(), irq_busy_bad);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL %s busy_after got %b want 0", name, busy);
    end
    $display("[TB] %s: %0d pixels, irq at +%0d", name, n, irq_cycle - c);
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step(1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(i[0], 8'hB0, 8'(8'h11 * i));
      n_tests++;
      if ({busy, done_irq} !== 2'b00) begin
        n_fail++; $display("[TB] FAIL reset_idle cyc=%0d got busy=%b irq=%b want 0 0", cyc, busy, done_irq);
      end
    end
  endtask

  task automatic test_basic_fill;
    run_fill("basic", 10, 20, 11, 21);
  endtask

  task automatic test_empty;
    run_fill("empty", 5, 0, 3, 0);
  endtask

  task automatic test_clamp;
    run_fill("clamp", 158, 118, 200, 127);
  endtask

  // CPU write lands on the first WR_X of every pixel (cycles c+3+4i).
  task automatic test_stall;
    int n, c;
    program_rect(8'd10, 8'd20, 8'd11, 8'd21);
    n = push_fill(10, 20, 11, 21, 1000);
    irq_count = 0; irq_cycle = -1;
    c = cyc;
    step(1'b1, 8'hB8, 8'h01);
    for (int t = 1; t < 80 && irq_count == 0; t++) begin
      if (t >= 3 && ((t - 3) % 4) == 0 && ((t - 3) / 4) < n) step(1'b1, 8'hB0, 8'(8'hA0 + t));
      else step(1'b0, 8'h00, 8'h00);
    end
    repeat (3) step(1'b0, 8'h00, 8'h00);
    n_tests++;
    if (irq_count != 1 || irq_cycle != c + 2 + 3 * n + n) begin
      n_fail++; $display("[TB] FAIL stall_irq got count=%0d at +%0d want 1 at +%0d", irq_count, irq_cycle - c, 2 + 4 * n);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL stall_leftover got %0d want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_abort;
    int c;
    program_rect(8'd10, 8'd20, 8'd11, 8'd21);
    void'(push_fill(10, 20, 11, 21, 3));
    irq_count = 0;
    c = cyc;
    step(1'b1, 8'hB8, 8'h01);
    repeat (10) step(1'b0, 8'h00, 8'h00);
    step(1'b1, 8'hB8, 8'h02);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_busy got %b want 0", busy);
    end
    busy_hi = 0;
    repeat (5) step(1'b0, 8'h00, 8'h00);
    step(1'b1, 8'hB8, 8'h03);
    repeat (20) step(1'b0, 8'h00, 8'h00);
    n_tests++;
    if (irq_count != 0 || busy_hi != 0) begin
      n_fail++; $display("[TB] FAIL abort_quiet got irq=%0d busy_cycles=%0d want 0 0", irq_count, busy_hi);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL abort_leftover got %0d want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Reset asserted in the GAP of the first pixel: engine stops, no IRQ.
  task automatic test_reset_midfill;
    program_rect(8'd10, 8'd20, 8'd11, 8'd21);
    void'(push_fill(10, 20, 11, 21, 1));
    irq_count = 0;
    step(1'b1, 8'hB8, 8'h01);
    repeat (3) step(1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    step(1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    busy_hi = 0;
    repeat (20) step(1'b0, 8'h00, 8'h00);
    n_tests++;
    if (irq_count != 0 || busy_hi != 0 || exp_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL reset_midfill got irq=%0d busy=%0d left=%0d want 0 0 0", irq_count, busy_hi, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; bus_we = 1'b0; bus_addr = 8'h00; bus_data = 8'h00;
    @(posedge clk); #1;
    test_reset;
    test_basic_fill;
    test_stall;
    test_empty;
    test_clamp;
    test_abort;
    test_reset_midfill;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
